hex_operand_entry: RTL and testbench
====================================

# hex_operand_entry

Sequential front end of the hexadecimal 8-bit adder. It assembles two 8-bit operands from single hex-digit key events, accepting up to two digits per operand. It then presents the operand pair to the adder datapath (the half/full-adder chain) through a valid/ready handshake. It sits directly upstream of the adder and holds both operands stable for as long as the adder stage needs them.

## Interface
Parameters: none. All widths are fixed: 8-bit operands, 4-bit digits.

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- KeyDigitValid  in  1  one-cycle pulse: KeyDigit holds a new hex digit
- KeyDigit  in  4  hex digit 0x0–0xF
- KeyEnter  in  1  one-cycle pulse: close current operand
- KeyClear  in  1  one-cycle pulse: abort entry, clear everything
- OpReady  in  1  adder stage can accept the operand pair this cycle
- OpA  out  8  first operand, registered
- OpB  out  8  second operand, registered
- OpValid  out  1  OpA/OpB pair is complete and stable
- EntryState  out  2  00 = ENTER_A, 01 = ENTER_B, 10 = PRESENT (11 never driven)
- DigitCnt  out  2  digits accepted into the current operand, saturates at 2

## Operation
- Reset (Rst=1 at an edge) → OpA=0x00, OpB=0x00, OpValid=0, EntryState=ENTER_A, DigitCnt=0. Reset overrides every other input, including in PRESENT.
- Digit rule: the current operand register becomes {Op[3:0], KeyDigit}, a shift-left by one nibble. DigitCnt increments and saturates at 2. A third or later digit keeps shifting, so the last two digits are retained.
- Priority when pulses coincide: KeyClear > KeyEnter > KeyDigitValid. Only the highest-priority event acts; the others are dropped.
- ENTER_A:
  - Digit → shifts into OpA.
  - Enter → go to ENTER_B, DigitCnt=0. An Enter with zero digits is legal and gives operand 0x00.
- ENTER_B:
  - Digit → shifts into OpB.
  - Enter → go to PRESENT, OpValid=1, DigitCnt=0.
- PRESENT:
  - OpA and OpB are frozen.
  - KeyDigitValid and KeyEnter are ignored.
  - Transfer happens at any edge with OpValid=1 and OpReady=1. At that edge: OpValid=0, OpA=OpB=0x00, state goes to ENTER_A.
- KeyClear in any state → same result as reset (all outputs at reset values, ENTER_A).
- OpReady is ignored outside PRESENT.
- OpValid, once asserted, stays high until a transfer, KeyClear or Rst. It never drops on its own.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- An event sampled at edge k is reflected on the outputs after edge k, i.e. visible during cycle k+1.
- Enter in ENTER_B at edge k → OpValid=1 during cycle k+1.
- If OpReady is held high continuously, OpValid is high for exactly one cycle.
- If OpReady is low, OpValid holds indefinitely and OpA/OpB do not change.
- The earliest new digit accepted after a transfer is the one sampled at the edge following the transfer edge. A digit coincident with the transfer edge is dropped, because the block is in PRESENT at that edge.
- Back-to-back key pulses on consecutive cycles are all processed; the block has no busy cycles in ENTER_A or ENTER_B.

## Test plan
- Reset check: hold Rst 2 cycles with random key inputs → OpA=OpB=0x00, OpValid=0, EntryState=00, DigitCnt=0.
- Basic entry: digits 3,C, Enter, digits 0,5, Enter, with OpReady=0.
  - Required: OpA=0x3C, OpB=0x05, EntryState=10, OpValid=1 one cycle after the second Enter.
  - Then assert OpReady → OpValid=0 and EntryState=00 the next cycle, both operands 0x00.
- Overflow digits: digits 1,2,3 then Enter → OpA=0x23 and DigitCnt stays at 2 after the third digit. An Enter with no digits for B → OpB=0x00.
- Backpressure: reach PRESENT with OpA=0xFF, OpB=0x01, keep OpReady=0 for 10 cycles and send digit 7 plus Enter.
  - Required: OpValid stays 1, and the operands stay 0xFF and 0x01.
  - Then OpReady=1 for 1 cycle → a single transfer.
- Priority and clear: in ENTER_B with OpA=0x12, pulse KeyClear+KeyEnter+KeyDigitValid in the same cycle → everything goes to reset values with EntryState=00. Separately, a KeyClear in PRESENT drops OpValid the next cycle.
- Mid-operation reset: Rst asserted at the same edge as OpValid&OpReady → reset values take effect; no residual OpValid.

Source files
------------

// File: rtl/hex_operand_entry.sv
// hex_operand_entry: assembles two 8-bit operands from hex key events and
// presents them to the adder datapath over a valid/ready handshake.
module hex_operand_entry (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       KeyDigitValid,
    input  logic [3:0] KeyDigit,
    input  logic       KeyEnter,
    input  logic       KeyClear,
    input  logic       OpReady,
    output logic [7:0] OpA,
    output logic [7:0] OpB,
    output logic       OpValid,
    output logic [1:0] EntryState,
    output logic [1:0] DigitCnt
);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        PRESENT = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] opa_d, opb_d;
    logic       valid_d;
    logic [1:0] cnt_d;
    logic [1:0] cnt_inc;

    assign EntryState = state_q;

    // State and output registers; reset wins over every key event.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ENTER_A;
            OpA      <= '0;
            OpB      <= '0;
            OpValid  <= 1'b0;
            DigitCnt <= '0;
        end else begin
            state_q  <= state_d;
            OpA      <= opa_d;
            OpB      <= opb_d;
            OpValid  <= valid_d;
            DigitCnt <= cnt_d;
        end
    end

    // Next-state logic: KeyClear > KeyEnter > KeyDigitValid; only one acts.
    always_comb begin
        state_d = state_q;
        opa_d   = OpA;
        opb_d   = OpB;
        valid_d = OpValid;
        cnt_d   = DigitCnt;
        cnt_inc = (DigitCnt == 2'd2) ? 2'd2 : DigitCnt + 2'd1;

        if (KeyClear) begin
            state_d = ENTER_A;
            opa_d   = '0;
            opb_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (KeyEnter) begin
                        state_d = ENTER_B;
                        cnt_d   = '0;
                    end else if (KeyDigitValid) begin
                        opa_d = {OpA[3:0], KeyDigit};
                        cnt_d = cnt_inc;
                    end
                end
                ENTER_B: begin
                    if (KeyEnter) begin
                        state_d = PRESENT;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else if (KeyDigitValid) begin
                        opb_d = {OpB[3:0], KeyDigit};
                        cnt_d = cnt_inc;
                    end
                end
                PRESENT: begin
                    // Operands frozen; keys ignored until the adder takes the pair.
                    if (OpValid && OpReady) begin
                        state_d = ENTER_A;
                        opa_d   = '0;
                        opb_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ENTER_A;
                    opa_d   = '0;
                    opb_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_operand_entry.sv
// tb_hex_operand_entry: directed stimulus with a transfer scoreboard.
module tb_hex_operand_entry;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       KeyDigitValid = 1'b0;
    logic [3:0] KeyDigit = '0;
    logic       KeyEnter = 1'b0;
    logic       KeyClear = 1'b0;
    logic       OpReady = 1'b0;
    logic [7:0] OpA, OpB;
    logic       OpValid;
    logic [1:0] EntryState, DigitCnt;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    pair_t sb[$];
    int total = 0;
    int bad   = 0;
    int xfers = 0;

    hex_operand_entry dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .KeyDigitValid(KeyDigitValid),
        .KeyDigit     (KeyDigit),
        .KeyEnter     (KeyEnter),
        .KeyClear     (KeyClear),
        .OpReady      (OpReady),
        .OpA          (OpA),
        .OpB          (OpB),
        .OpValid      (OpValid),
        .EntryState   (EntryState),
        .DigitCnt     (DigitCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer edge is coming whenever the pair is offered and accepted.
    always @(negedge Clk) begin
        if (OpValid && OpReady && !Rst && !KeyClear) begin
            pair_t e;
            xfers++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: got A=%h B=%h expected no transfer", OpA, OpB);
            end else begin
                e = sb.pop_front();
                if (OpA !== e.a || OpB !== e.b) begin
                    bad++;
                    $display("FAIL xfer_pair: got A=%h B=%h expected A=%h B=%h", OpA, OpB, e.a, e.b);
                end
            end
        end
    end

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic digit(input logic [3:0] d);
        KeyDigitValid = 1'b1;
        KeyDigit      = d;
        step();
        KeyDigitValid = 1'b0;
    endtask

    task automatic enter;
        KeyEnter = 1'b1;
        step();
        KeyEnter = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_opa"},   OpA, 8'h00);
        chk({tag, "_opb"},   OpB, 8'h00);
        chk({tag, "_valid"}, 8'(OpValid), 8'd0);
        chk({tag, "_state"}, 8'(EntryState), 8'd0);
        chk({tag, "_cnt"},   8'(DigitCnt), 8'd0);
    endtask

    task automatic release_one;
        OpReady = 1'b1;
        step();
        OpReady = 1'b0;
    endtask

    initial begin
        int x0;

        // Reset with random key activity
        Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            KeyDigitValid = 1'($urandom);
            KeyDigit      = 4'($urandom);
            KeyEnter      = 1'($urandom);
            KeyClear      = 1'($urandom);
            OpReady       = 1'($urandom);
            step();
        end
        Rst = 1'b0; KeyDigitValid = 1'b0; KeyEnter = 1'b0; KeyClear = 1'b0; OpReady = 1'b0;
        chk_reset_vals("reset");

        // Basic entry
        digit(4'h3);
        chk("basic_cnt1", 8'(DigitCnt), 8'd1);
        digit(4'hC);
        chk("basic_opa", OpA, 8'h3C);
        chk("basic_cnt2", 8'(DigitCnt), 8'd2);
        enter();
        chk("basic_stateB", 8'(EntryState), 8'd1);
        chk("basic_cnt0", 8'(DigitCnt), 8'd0);
        digit(4'h0);
        digit(4'h5);
        sb.push_back('{a: 8'h3C, b: 8'h05});
        enter();
        chk("basic_valid", 8'(OpValid), 8'd1);
        chk("basic_stateP", 8'(EntryState), 8'd2);
        chk("basic_opb", OpB, 8'h05);
        release_one();
        chk_reset_vals("basic_after");

        // Overflow digits and empty operand B
        digit(4'h1);
        digit(4'h2);
        digit(4'h3);
        chk("ovf_opa", OpA, 8'h23);
        chk("ovf_cnt", 8'(DigitCnt), 8'd2);
        enter();
        sb.push_back('{a: 8'h23, b: 8'h00});
        enter();
        chk("ovf_opb", OpB, 8'h00);
        chk("ovf_valid", 8'(OpValid), 8'd1);
        release_one();
        chk("ovf_after_valid", 8'(OpValid), 8'd0);

        // Backpressure: keys ignored, pair frozen
        digit(4'hF); digit(4'hF); enter();
        digit(4'h0); digit(4'h1);
        sb.push_back('{a: 8'hFF, b: 8'h01});
        enter();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                digit(4'h7);
            end else if (i == 5) begin
                enter();
            end else begin
                step();
            end
            chk("bp_valid", 8'(OpValid), 8'd1);
            chk("bp_opa", OpA, 8'hFF);
            chk("bp_opb", OpB, 8'h01);
        end
        x0 = xfers;
        release_one();
        chk("bp_valid_drop", 8'(OpValid), 8'd0);
        step(); step();
        chk("bp_single_xfer", 8'(xfers - x0), 8'd1);

        // Priority: clear beats enter and digit
        digit(4'h1); digit(4'h2); enter();
        chk("pri_opa_pre", OpA, 8'h12);
        KeyClear = 1'b1; KeyEnter = 1'b1; KeyDigitValid = 1'b1; KeyDigit = 4'h9;
        step();
        KeyClear = 1'b0; KeyEnter = 1'b0; KeyDigitValid = 1'b0;
        chk_reset_vals("pri");

        // Clear in PRESENT
        digit(4'h4); enter(); digit(4'h6); enter();
        chk("clr_valid_pre", 8'(OpValid), 8'd1);
        KeyClear = 1'b1;
        step();
        KeyClear = 1'b0;
        chk_reset_vals("clr");

        // Digit coincident with transfer edge is dropped
        digit(4'hA); enter(); digit(4'hB);
        sb.push_back('{a: 8'h0A, b: 8'h0B});
        enter();
        OpReady = 1'b1; KeyDigitValid = 1'b1; KeyDigit = 4'h9;
        step();
        OpReady = 1'b0; KeyDigitValid = 1'b0;
        chk("drop_opa", OpA, 8'h00);
        chk("drop_cnt", 8'(DigitCnt), 8'd0);
        digit(4'h9);
        chk("post_xfer_digit", OpA, 8'h09);
        KeyClear = 1'b1; step(); KeyClear = 1'b0;

        // Reset coincident with a transfer
        digit(4'h5); enter(); digit(4'h6); enter();
        OpReady = 1'b1; Rst = 1'b1;
        step();
        OpReady = 1'b0; Rst = 1'b0;
        chk_reset_vals("midrst");
        step();
        chk("midrst_valid_later", 8'(OpValid), 8'd0);

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
